// File: rtl/vector_pkg.sv
// rtl/vector_pkg.sv - shared vector-unit types and widths for the operand buffer
package vector_pkg;

    localparam int READ_PORTS     = 4;
    localparam int MASK_PORTS     = 2;
    localparam int VIDX_W         = 8;
    localparam int VREG_W         = 32;
    localparam int VMASK_W        = 8;
    localparam int OPBUFF_STALL_W = 8;

    typedef logic [VREG_W-1:0]  vreg_t;
    typedef logic [VMASK_W-1:0] vmask_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ISSUE   = 2'd2
    } opbuff_state_t;

    typedef struct packed {
        vreg_t  [READ_PORTS-1:0] vreg;
        vmask_t [MASK_PORTS-1:0] vmask;
        logic   [MASK_PORTS-1:0] ivalid;
    } opbuff_out_t;

endpackage

// File: rtl/vector_opbuff.sv
// rtl/vector_opbuff.sv - collects per-port register and mask operands, then issues them as one set
module vector_opbuff
    import vector_pkg::*;
(
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [READ_PORTS-1:0]         req_rmask,
    input  logic [MASK_PORTS-1:0]         req_mmask,
    input  logic [VIDX_W-1:0]             req_vd,
    input  vreg_t [READ_PORTS-1:0]        vreg_in,
    input  logic [READ_PORTS-1:0]         dvalid_in,
    input  vmask_t [MASK_PORTS-1:0]       vmask_in,
    input  logic [MASK_PORTS-1:0]         mvalid_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output opbuff_out_t                   out_ops,
    output logic [VIDX_W-1:0]             out_vd,
    output logic [OPBUFF_STALL_W-1:0]     stall_cnt
);

    opbuff_state_t                 state_q, state_d;
    logic [READ_PORTS-1:0]         rpend_q, rpend_d, rcap;
    logic [MASK_PORTS-1:0]         mpend_q, mpend_d, mcap;
    vreg_t [READ_PORTS-1:0]        vreg_q, vreg_d;
    vmask_t [MASK_PORTS-1:0]       vmask_q, vmask_d;
    logic [MASK_PORTS-1:0]         ivalid_q, ivalid_d;
    logic [VIDX_W-1:0]             vd_q, vd_d;
    logic [OPBUFF_STALL_W-1:0]     stall_q, stall_d;

    logic accept;
    logic collect;

    assign accept  = (state_q == IDLE) && req_valid;
    assign collect = (state_q == COLLECT);

    // Per read port: capture only while pending, clear pending on the capturing edge; accept zeroes data
    for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
        assign rcap[i]    = collect && rpend_q[i] && dvalid_in[i];
        assign rpend_d[i] = accept ? req_rmask[i] : (rpend_q[i] && !rcap[i]);
        assign vreg_d[i]  = accept ? '0 : (rcap[i] ? vreg_in[i] : vreg_q[i]);
    end

    // Per mask port: same first-capture-wins policy as the read ports
    for (genvar j = 0; j < MASK_PORTS; j++) begin : g_mk
        assign mcap[j]     = collect && mpend_q[j] && mvalid_in[j];
        assign mpend_d[j]  = accept ? req_mmask[j] : (mpend_q[j] && !mcap[j]);
        assign vmask_d[j]  = accept ? '0 : (mcap[j] ? vmask_in[j] : vmask_q[j]);
    end

    // Sequencing: accept, collect until nothing pending, hold the set until the lanes take it
    always_comb begin
        state_d  = state_q;
        ivalid_d = ivalid_q;
        vd_d     = vd_q;
        stall_d  = stall_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    vd_d     = req_vd;
                    ivalid_d = req_mmask;
                    stall_d  = '0;
                    state_d  = ((|req_rmask) || (|req_mmask)) ? COLLECT : ISSUE;
                end
            end
            COLLECT: begin
                if (!(|rcap) && !(|mcap) && (stall_q != {OPBUFF_STALL_W{1'b1}})) begin
                    stall_d = stall_q + OPBUFF_STALL_W'(1);
                end
                if (!(|rpend_d) && !(|mpend_d)) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any in-flight instruction
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= IDLE;
            rpend_q  <= '0;
            mpend_q  <= '0;
            vreg_q   <= '0;
            vmask_q  <= '0;
            ivalid_q <= '0;
            vd_q     <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            rpend_q  <= rpend_d;
            mpend_q  <= mpend_d;
            vreg_q   <= vreg_d;
            vmask_q  <= vmask_d;
            ivalid_q <= ivalid_d;
            vd_q     <= vd_d;
            stall_q  <= stall_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign out_valid = (state_q == ISSUE);
    assign out_ops   = {vreg_q, vmask_q, ivalid_q};
    assign out_vd    = vd_q;
    assign stall_cnt = stall_q;

endmodule

// File: doc/vector_opbuff.md
VECTOR_OPBUFF -- requirements
Module: vector_opbuff

Interface
REQ-001 CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 nRST  in  1  reset, synchronous, active-low.
REQ-003 req_valid  in  1  dispatch presents an instruction for operand collection.
REQ-004 req_ready  out  1  buffer can accept a request this cycle.
REQ-005 req_rmask  in  READ_PORTS  read ports whose operand the instruction needs.
REQ-006 req_mmask  in  MASK_PORTS  mask ports whose mask the instruction needs.
REQ-007 req_vd  in  VIDX_W  destination tag, carried through unchanged.
REQ-008 vreg_in  in  READ_PORTS x vreg_t  register-file read data per port.
REQ-009 dvalid_in  in  READ_PORTS  per-port read-data valid from register file.
REQ-010 vmask_in  in  MASK_PORTS x vmask_t  mask read data per port.
REQ-011 mvalid_in  in  MASK_PORTS  per-port mask valid.
REQ-012 out_valid  out  1  collected operand set available to lanes.
REQ-013 out_ready  in  1  lanes accept operand set.
REQ-014 out_ops  out  opbuff_out_t  vreg, vmask, and ivalid (copy of latched req_mmask).
REQ-015 out_vd  out  VIDX_W  latched destination tag.
REQ-016 stall_cnt  out  OPBUFF_STALL_W (8)  collect cycles with no capture, saturating.

Function
REQ-017 FSM states IDLE, COLLECT, ISSUE; req_ready SHALL be 1 only in IDLE.
REQ-018 IDLE with req_valid: latch req_rmask/req_mmask as pending bits, latch req_vd, zero all captured vreg/vmask, clear stall_cnt.
REQ-019 IDLE accept with req_rmask==0 and req_mmask==0 SHALL go directly to ISSUE; otherwise to COLLECT.
REQ-020 Data/valid inputs in the accept cycle SHALL NOT be captured; register-file latency is at least one cycle.
REQ-021 COLLECT: for each port with pending bit set and its dvalid_in/mvalid_in high, capture data and clear that pending bit the same edge.
REQ-022 Valids on non-pending or already-captured ports SHALL be ignored; first capture wins, later data never overwrites.
REQ-023 Ports may complete in any order and over any number of cycles; simultaneous captures on all ports in one cycle are legal.
REQ-024 When the last pending bit clears at edge N, state SHALL be ISSUE and out_valid=1 from edge N (one cycle after the final valid was sampled).
REQ-025 ISSUE: out_valid, out_ops, out_vd held stable until out_ready=1; on handshake edge go IDLE.
REQ-026 No same-cycle issue/accept: at least one IDLE cycle between consecutive instructions.
REQ-027 out_valid SHALL be 0 outside ISSUE; out_ops fields of unrequested ports SHALL be zero.
REQ-028 stall_cnt increments each COLLECT cycle where no capture occurs, saturates at 255, holds in ISSUE, clears on accept.
REQ-029 out_ready while not in ISSUE SHALL have no effect.

Reset
REQ-030 nRST low at an edge: state IDLE, pending bits 0, captured data 0, out_vd 0, stall_cnt 0, out_valid 0; req_ready 1 from the first edge after nRST returns high.
REQ-031 Reset mid-COLLECT or mid-ISSUE SHALL discard the in-flight instruction without emitting out_valid.

Structure
REQ-032 opbuff_state_t enum (IDLE, COLLECT, ISSUE) and OPBUFF_STALL_W = 8 SHALL be added to vector_pkg; widths derive from READ_PORTS, MASK_PORTS, VIDX_W.
REQ-033 No sub-module; per-port capture logic SHALL be a generate loop over READ_PORTS and MASK_PORTS.

Verification
REQ-034 Accept rmask=4'b0011, mmask=0, vd=8'h05; dvalid[0] at +1, dvalid[1] at +3 -> out_valid at +4, vreg[0..1] match, vreg[2..3]=0, out_vd=8'h05, stall_cnt=1.
REQ-035 Accept rmask=0, mmask=0 -> out_valid the next cycle, all data 0, ivalid=0.
REQ-036 rmask=4'b0001, dvalid[0] pulsed twice with data A then B -> out_ops.vreg[0]=A.
REQ-037 In ISSUE hold out_ready=0 for 3 cycles -> outputs stable, req_ready=0; out_ready=1 -> IDLE next edge, req_ready=1.
REQ-038 rmask=4'b1111, mmask=2'b11, no valids for 300 cycles -> stall_cnt=255; nRST low one edge -> all outputs reset, no out_valid.
